block_scheduler: RTL
====================

Name: block_scheduler

Overview:
- Next-generation block dispatcher. Distributes the blocks of one kernel launch across up to NUM_CORES compute cores.
- Adds four things: a runtime core-enable mask, round-robin one-grant-per-cycle issue, a per-core recycle pulse, and abort support.
- Sits between the GPU top-level control (start/abort/done) and the per-core start/reset/block-id inputs.
- Reports progress and completion status back to the host-facing control registers.

Parameters:
- NUM_CORES, 4, number of cores driven; 1..32.
- ID_WIDTH, 8, width of block ids and block counters; max kernel size 2^ID_WIDTH-1 blocks.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- start  input  1  level; launch on rising edge (sampled high while registered copy low).
- abort  input  1  level; terminate the running launch.
- num_blocks  input  ID_WIDTH  blocks in this launch; latched at launch.
- core_enable  input  NUM_CORES  cores allowed to receive blocks; latched at launch.
- core_done  input  NUM_CORES  per-core block-complete flag.
- core_start  output  NUM_CORES  per-core run request.
- core_reset  output  NUM_CORES  per-core reset.
- core_block_id  output  NUM_CORES*ID_WIDTH  flattened; core i occupies bits [i*ID_WIDTH +: ID_WIDTH].
- blocks_done  output  ID_WIDTH  completed-block count for the current launch.
- busy  output  1  high in DISPATCH.
- done  output  1  high in DONE.
- aborted  output  1  high in DONE if the launch ended by abort or with an empty core_enable.

Behaviour:
- Reset values:
  - state IDLE.
  - core_start 0, core_reset all 1, core_block_id 0.
  - blocks_done 0, dispatched counter 0.
  - busy 0, done 0, aborted 0.
  - round-robin pointer 0, start_q 0.
- IDLE:
  - core_reset held all 1.
  - On start & !start_q:
    - latch num_blocks into N and core_enable into M.
    - clear both counters.
    - if N==0: go DONE, aborted=0.
    - else if M==0: go DONE, aborted=1.
    - else: go DISPATCH; core_reset[i]<=~M[i], so disabled cores stay in reset.
- Per-core sub-state in DISPATCH: FREE, RUN, RECYCLE.
  - FREE: core_start=0, core_reset=0. Eligible for a grant.
  - Grant:
    - at most one per cycle.
    - goes to the first eligible FREE enabled core at or after the pointer, modulo NUM_CORES.
    - only while dispatched<N.
    - effect: core_block_id[i]<=dispatched, core_start[i]<=1, dispatched++, pointer<=i+1 (wrapping), core i -> RUN.
  - RUN: when core_start[i] & core_done[i]:
    - core_start[i]<=0, core_reset[i]<=1, core i -> RECYCLE.
    - blocks_done increments by the count of cores completing that cycle; simultaneous completions all count.
  - RECYCLE: lasts exactly one cycle; core_reset[i]<=0, core i -> FREE. Earliest re-grant is the following cycle.
  - core_done is ignored in FREE and RECYCLE.
  - core_block_id holds its value until the next grant to that core.
- DISPATCH -> DONE:
  - taken when blocks_done (including this cycle's increments) reaches N.
  - done<=1, busy<=0, core_start all 0, core_reset all 1.
- Abort:
  - abort=1 in DISPATCH -> DONE next edge, aborted<=1, core_start all 0, core_reset all 1.
  - In that same cycle, abort has priority over both grants and completions.
  - abort in IDLE or DONE is ignored.
- DONE:
  - hold done and aborted; blocks_done remains readable.
  - When start is low: -> IDLE, done<=0, aborted<=0.
- Ignored inputs:
  - a start rising edge outside IDLE.
  - changes to num_blocks or core_enable after launch.
- Latency:
  - launch edge E0 -> DISPATCH and core_reset drop visible after E0.
  - first core_start visible after E0+1.
  - k-th grant no earlier than E0+k.
- Reset asserted mid-launch returns every register to its reset value on the next edge, including the DONE/DISPATCH state.
- Counter widths: all ID_WIDTH, no wrap possible because dispatched<=N<=2^ID_WIDTH-1.

Test Plan:
- NUM_CORES=4, N=10, M=4'b1111, each core asserts core_done 3 cycles after its start -> ids 0..9 each issued exactly once; first grants go to cores 0,1,2,3 on consecutive cycles; done=1 with blocks_done=10 and aborted=0.
- M=4'b0101, N=5 -> only cores 0 and 2 ever see core_start; cores 1 and 3 keep core_reset=1 throughout; done with blocks_done=5.
- N=0 -> done=1 and aborted=0 one edge after the launch, no core_start ever pulses. Separately, N=4 with M=0 -> done=1 and aborted=1.
- Cores 0..3 assert core_done in the same cycle -> blocks_done rises by 4 in one edge; each of those cores shows a single-cycle core_reset pulse and is re-granted in later cycles.
- abort asserted while 3 blocks are in RUN, N=8 -> next edge: core_start=0 and core_reset=all 1, done=1, aborted=1, blocks_done frozen at its value. Deasserting start returns the block to IDLE with done=0.
- start held high through DONE -> no relaunch; drop start then raise it again -> new launch with the new num_blocks latched and counters cleared.

Source files
------------

// File: rtl/block_scheduler_if.sv
// Control/core bundle between the launch controller, the block scheduler and the cores.
// The scheduler connects through the slave modport; the host side drives the master modport.
interface block_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int ID_WIDTH  = 8
);
  logic                          start;
  logic                          abort;
  logic [ID_WIDTH-1:0]           num_blocks;
  logic [NUM_CORES-1:0]          core_enable;
  logic [NUM_CORES-1:0]          core_done;
  logic [NUM_CORES-1:0]          core_start;
  logic [NUM_CORES-1:0]          core_reset;
  logic [NUM_CORES*ID_WIDTH-1:0] core_block_id;
  logic [ID_WIDTH-1:0]           blocks_done;
  logic                          busy;
  logic                          done;
  logic                          aborted;

  modport master (
    output start, abort, num_blocks, core_enable, core_done,
    input  core_start, core_reset, core_block_id, blocks_done, busy, done, aborted
  );

  modport slave (
    input  start, abort, num_blocks, core_enable, core_done,
    output core_start, core_reset, core_block_id, blocks_done, busy, done, aborted
  );
endinterface

// File: rtl/block_scheduler.sv
// Round-robin block dispatcher: spreads one kernel launch over the enabled cores,
// one grant per cycle, with a one-cycle recycle reset between blocks and abort support.
module block_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int ID_WIDTH  = 8
) (
  input logic               clk,
  input logic               reset,
  block_scheduler_if.slave  bus
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  localparam logic [1:0] CS_FREE    = 2'd0;
  localparam logic [1:0] CS_RUN     = 2'd1;
  localparam logic [1:0] CS_RECYCLE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [1:0]           core_st_q [NUM_CORES];
  logic [1:0]           core_st_d [NUM_CORES];
  logic [ID_WIDTH-1:0]  id_q [NUM_CORES];
  logic [ID_WIDTH-1:0]  id_d [NUM_CORES];
  logic [NUM_CORES-1:0] cstart_q, cstart_d;
  logic [NUM_CORES-1:0] creset_q, creset_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [ID_WIDTH-1:0]  n_q, n_d;
  logic [ID_WIDTH-1:0]  disp_q, disp_d;
  logic [ID_WIDTH-1:0]  bd_q, bd_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 start_q;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic [NUM_CORES-1:0] elig_s, comp_s, grant_raw_s, grant_s;
  logic [ID_WIDTH-1:0]  comp_cnt_s, bd_next_s;
  logic                 launch_s, found_s, hit_s;
  int                   pos_s;

  // Per-core eligibility, completion detection and completion count.
  always_comb begin
    comp_cnt_s = '0;
    elig_s     = '0;
    comp_s     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      elig_s[i]  = (core_st_q[i] == CS_FREE) && mask_q[i];
      comp_s[i]  = (core_st_q[i] == CS_RUN) && cstart_q[i] && bus.core_done[i];
      comp_cnt_s = comp_cnt_s + ID_WIDTH'(comp_s[i]);
    end
    bd_next_s = bd_q + comp_cnt_s;
    launch_s  = bus.start && !start_q;
  end

  // Round-robin pick: first eligible core at or after the pointer, wrapping.
  always_comb begin
    grant_raw_s = '0;
    found_s     = 1'b0;
    hit_s       = 1'b0;
    pos_s       = 0;
    for (int off = 0; off < NUM_CORES; off++) begin
      pos_s = int'(ptr_q) + off;
      pos_s = (pos_s >= NUM_CORES) ? (pos_s - NUM_CORES) : pos_s;
      for (int i = 0; i < NUM_CORES; i++) begin
        hit_s          = !found_s && (i == pos_s) && elig_s[i];
        grant_raw_s[i] = grant_raw_s[i] | hit_s;
        found_s        = found_s | hit_s;
      end
    end
    grant_s = grant_raw_s & {NUM_CORES{disp_q < n_q}};
  end

  // Next-state logic for the launch FSM and the per-core sub-states.
  always_comb begin
    state_d   = state_q;
    cstart_d  = cstart_q;
    creset_d  = creset_q;
    mask_d    = mask_q;
    n_d       = n_q;
    disp_d    = disp_q;
    bd_d      = bd_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_st_d[i] = core_st_q[i];
      id_d[i]      = id_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        cstart_d = '0;
        creset_d = '1;
        if (launch_s) begin
          n_d    = bus.num_blocks;
          mask_d = bus.core_enable;
          disp_d = '0;
          bd_d   = '0;
          for (int i = 0; i < NUM_CORES; i++) begin
            core_st_d[i] = CS_FREE;
          end
          if (bus.num_blocks == '0) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            aborted_d = 1'b0;
          end else if (bus.core_enable == '0) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end else begin
            state_d  = ST_DISPATCH;
            busy_d   = 1'b1;
            creset_d = ~bus.core_enable;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DISPATCH: begin
        if (bus.abort) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          cstart_d  = '0;
          creset_d  = '1;
        end else begin
          for (int i = 0; i < NUM_CORES; i++) begin
            case (core_st_q[i])
              CS_FREE: begin
                if (grant_s[i]) begin
                  id_d[i]      = disp_q;
                  cstart_d[i]  = 1'b1;
                  core_st_d[i] = CS_RUN;
                  ptr_d        = (i == NUM_CORES - 1) ? '0 : PTR_W'(i + 1);
                end else begin
                  core_st_d[i] = CS_FREE;
                end
              end
              CS_RUN: begin
                if (comp_s[i]) begin
                  cstart_d[i]  = 1'b0;
                  creset_d[i]  = 1'b1;
                  core_st_d[i] = CS_RECYCLE;
                end else begin
                  core_st_d[i] = CS_RUN;
                end
              end
              CS_RECYCLE: begin
                creset_d[i]  = 1'b0;
                core_st_d[i] = CS_FREE;
              end
              default: begin
                core_st_d[i] = CS_FREE;
              end
            endcase
          end
          disp_d = disp_q + ID_WIDTH'(|grant_s);
          bd_d   = bd_next_s;
          // A completion that brings the count to N wins over everything else this cycle.
          if (bd_next_s == n_q) begin
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = 1'b0;
            cstart_d  = '0;
            creset_d  = '1;
          end else begin
            state_d = ST_DISPATCH;
          end
        end
      end

      ST_DONE: begin
        cstart_d = '0;
        creset_d = '1;
        if (!bus.start) begin
          state_d   = ST_IDLE;
          done_d    = 1'b0;
          aborted_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cstart_d = '0;
        creset_d = '1;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cstart_q  <= '0;
      creset_q  <= '1;
      mask_q    <= '0;
      n_q       <= '0;
      disp_q    <= '0;
      bd_q      <= '0;
      ptr_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_st_q[i] <= CS_FREE;
        id_q[i]      <= '0;
      end
    end else begin
      state_q   <= state_d;
      cstart_q  <= cstart_d;
      creset_q  <= creset_d;
      mask_q    <= mask_d;
      n_q       <= n_d;
      disp_q    <= disp_d;
      bd_q      <= bd_d;
      ptr_q     <= ptr_d;
      start_q   <= bus.start;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_st_q[i] <= core_st_d[i];
        id_q[i]      <= id_d[i];
      end
    end
  end

  // Drive registered outputs; block ids are packed core-major.
  always_comb begin
    bus.core_block_id = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      bus.core_block_id[i*ID_WIDTH +: ID_WIDTH] = id_q[i];
    end
    bus.core_start  = cstart_q;
    bus.core_reset  = creset_q;
    bus.blocks_done = bd_q;
    bus.busy        = busy_q;
    bus.done        = done_q;
    bus.aborted     = aborted_q;
  end

endmodule
